// File: rtl/oled_spi_tx_if.sv
// oled_spi_tx_if: write port and status flags between the OLED sequencer and oled_spi_tx.
interface oled_spi_tx_if;
    logic       wr_en;
    logic       wr_dc;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       done;

    modport slave (
        input  wr_en, wr_dc, wr_data,
        output full, empty, overflow, done
    );

    modport master (
        output wr_en, wr_dc, wr_data,
        input  full, empty, overflow, done
    );
endinterface

// File: rtl/oled_spi_tx.sv
// oled_spi_tx: queued {dc, byte} SPI transmitter (mode 0, MSB first) for the OLED panel.
// Define OLED_SPI_CS_EN to add the o_cs_n chip-select output; otherwise CS is tied low on the board.
module oled_spi_tx #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    oled_spi_tx_if.slave bus,
    output logic         o_sclk,
    output logic         o_sdin,
    output logic         o_dc
`ifdef OLED_SPI_CS_EN
    ,
    output logic         o_cs_n
`endif
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CNT_W = FIFO_AW + 1;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI
    } state_t;

    entry_t             r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_full;
    logic               r_overflow;

    state_t             r_state;
    logic [DIV_W-1:0]   r_div;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shreg;
    logic               r_empty;
    logic               r_done;
    logic               r_sclk;
    logic               r_sdin;
    logic               r_dc;
`ifdef OLED_SPI_CS_EN
    logic               r_cs_n;
`endif

    logic               w_push;
    logic               w_pop;
    logic               w_has_entry;
    logic [CNT_W-1:0]   w_count_nxt;
    entry_t             w_head;
    logic               w_phase_end;

    // Accept on the current count; the FIFO drains only during LOAD.
    assign w_push      = bus.wr_en & ~r_full;
    assign w_pop       = (r_state == S_LOAD);
    // A same-cycle write counts so a write into an idle block reaches LOAD one cycle later.
    assign w_has_entry = (r_count != '0) | w_push;
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_phase_end = (r_div == '0);

    // FIFO storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge i_clk) begin
        if (i_rst && w_push) begin
            r_mem[r_wr_ptr] <= entry_t'({bus.wr_dc, bus.wr_data});
        end
    end

    // FIFO pointers, occupancy, full flag and sticky overflow.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == CNT_W'(DEPTH));
            r_overflow <= r_overflow | (bus.wr_en & r_full);
        end
    end

    // Transfer sequencer: load a byte, then 8 low/high sclk phases of CLK_DIV cycles each.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_empty   <= 1'b1;
            r_done    <= 1'b0;
            r_sclk    <= 1'b0;
            r_sdin    <= 1'b0;
            r_dc      <= 1'b0;
`ifdef OLED_SPI_CS_EN
            r_cs_n    <= 1'b1;
`endif
        end else begin
            r_done  <= 1'b0;
            r_empty <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_sclk <= 1'b0;
                    if (w_has_entry) begin
                        r_state <= S_LOAD;
`ifdef OLED_SPI_CS_EN
                        r_cs_n  <= 1'b0;
`endif
                    end else begin
                        r_empty <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_dc      <= w_head.dc;
                    r_shreg   <= w_head.data;
                    r_sdin    <= w_head.data[7];
                    r_bit_cnt <= 3'd7;
                    r_sclk    <= 1'b0;
                    r_div     <= DIV_LOAD;
                    r_state   <= S_SHIFT_LO;
                end
                S_SHIFT_LO: begin
                    if (w_phase_end) begin
                        r_sclk  <= 1'b1;
                        r_div   <= DIV_LOAD;
                        r_state <= S_SHIFT_HI;
                    end else begin
                        r_div <= r_div - DIV_W'(1);
                    end
                end
                S_SHIFT_HI: begin
                    if (w_phase_end) begin
                        r_sclk <= 1'b0;
                        if (r_bit_cnt != 3'd0) begin
                            r_bit_cnt <= r_bit_cnt - 3'd1;
                            r_sdin    <= r_shreg[6];
                            r_shreg   <= {r_shreg[6:0], 1'b0};
                            r_div     <= DIV_LOAD;
                            r_state   <= S_SHIFT_LO;
                        end else begin
                            r_done <= 1'b1;
                            if (w_has_entry) begin
                                r_state <= S_LOAD;
                            end else begin
                                r_state <= S_IDLE;
                                r_empty <= 1'b1;
`ifdef OLED_SPI_CS_EN
                                r_cs_n  <= 1'b1;
`endif
                            end
                        end
                    end else begin
                        r_div <= r_div - DIV_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.full     = r_full;
    assign bus.empty    = r_empty;
    assign bus.overflow = r_overflow;
    assign bus.done     = r_done;
    assign o_sclk       = r_sclk;
    assign o_sdin       = r_sdin;
    assign o_dc         = r_dc;
`ifdef OLED_SPI_CS_EN
    assign o_cs_n       = r_cs_n;
`endif

endmodule
